// File: rtl/vdp_sprite_pkg.sv
// Shared definitions for the sprite metadata loader: block one-hot codes, table size, DMA states.
package vdp_sprite_pkg;

  localparam int SPRITE_COUNT = 256;
  localparam int IDX_W        = $clog2(SPRITE_COUNT);

  localparam logic [2:0] SPRITE_META_X = 3'b001;
  localparam logic [2:0] SPRITE_META_Y = 3'b010;
  localparam logic [2:0] SPRITE_META_G = 3'b100;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_REQ,
    DMA_WAIT,
    DMA_WRITE,
    DMA_NEXT
  } dma_state_t;

  function automatic logic [2:0] lowest_onehot(input logic [2:0] m);
    return m & (~m + 3'd1);
  endfunction

  // Position of a block inside the source table (x, y, g laid out back to back).
  function automatic logic [1:0] blk_index(input logic [2:0] oh);
    if (oh == SPRITE_META_G) return 2'd2;
    if (oh == SPRITE_META_Y) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/vdp_sprite_meta_write_mux.sv
// Registered merge of CPU and DMA metadata writes; CPU always wins, DMA is told via o_dma_grant.
module vdp_sprite_meta_write_mux
  import vdp_sprite_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cpu_we,
  input  logic [IDX_W-1:0] i_cpu_addr,
  input  logic [15:0]      i_cpu_dat,
  input  logic [2:0]       i_cpu_blk,
  input  logic             i_dma_req,
  input  logic [IDX_W-1:0] i_dma_addr,
  input  logic [15:0]      i_dma_dat,
  input  logic [2:0]       i_dma_blk,
  output logic             o_dma_grant,
  output logic [IDX_W-1:0] o_meta_addr,
  output logic [15:0]      o_meta_dat,
  output logic [2:0]       o_meta_blk,
  output logic             o_meta_we
);

  logic [IDX_W-1:0] r_addr;
  logic [15:0]      r_dat;
  logic [2:0]       r_blk;
  logic             r_we;

  assign o_dma_grant = i_dma_req & ~i_cpu_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_dat  <= '0;
      r_blk  <= '0;
      r_we   <= 1'b0;
    end else if (i_cpu_we) begin
      r_addr <= i_cpu_addr;
      r_dat  <= i_cpu_dat;
      r_blk  <= i_cpu_blk;
      r_we   <= 1'b1;
    end else if (i_dma_req) begin
      r_addr <= i_dma_addr;
      r_dat  <= i_dma_dat;
      r_blk  <= i_dma_blk;
      r_we   <= 1'b1;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign o_meta_addr = r_addr;
  assign o_meta_dat  = r_dat;
  assign o_meta_blk  = r_blk;
  assign o_meta_we   = r_we;

endmodule

// File: rtl/vdp_sprite_meta_dma.sv
// Vblank-gated bulk copy of sprite x/y/g attribute blocks from VRAM into the sprite metadata port,
// one read outstanding at a time, merged with CPU metadata writes that always take priority.
module vdp_sprite_meta_dma
  import vdp_sprite_pkg::*;
#(
  parameter int SRC_AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [IDX_W-1:0]  count,
  input  logic [2:0]        block_mask,
  input  logic              vblank,
  input  logic [IDX_W-1:0]  cpu_address,
  input  logic [15:0]       cpu_write_data,
  input  logic [2:0]        cpu_block_select,
  input  logic              cpu_we,
  output logic [SRC_AW-1:0] src_read_address,
  output logic              src_read_req,
  input  logic [15:0]       src_read_data,
  input  logic              src_data_valid,
  output logic [IDX_W-1:0]  meta_address,
  output logic [15:0]       meta_write_data,
  output logic [2:0]        meta_block_select,
  output logic              meta_we,
  output logic              busy,
  output logic              done
);

  dma_state_t        r_state;
  logic [SRC_AW-1:0] r_base;
  logic [IDX_W-1:0]  r_count;
  logic [2:0]        r_mask;
  logic [2:0]        r_blk;
  logic [IDX_W-1:0]  r_idx;
  logic [15:0]       r_hold;
  logic [SRC_AW-1:0] r_src_addr;
  logic              r_src_req;
  logic              r_busy;
  logic              r_done;

  logic              w_dma_grant;
  logic              w_dma_req;
  logic [SRC_AW-1:0] w_offset;
  logic [IDX_W:0]    w_idx_inc;
  logic              w_last_idx;
  logic [2:0]        w_next_blk;

  assign w_dma_req  = (r_state == DMA_WRITE);
  assign w_offset   = SRC_AW'({blk_index(r_blk), r_idx});
  assign w_idx_inc  = {1'b0, r_idx} + {{IDX_W{1'b0}}, 1'b1};
  // A count of zero stands for a full block, so compare against count with an extra top bit.
  assign w_last_idx = (w_idx_inc == {(r_count == '0), r_count});
  assign w_next_blk = lowest_onehot(r_mask & ~(r_blk | (r_blk - 3'd1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= DMA_IDLE;
      r_base     <= '0;
      r_count    <= '0;
      r_mask     <= '0;
      r_blk      <= '0;
      r_idx      <= '0;
      r_hold     <= '0;
      r_src_addr <= '0;
      r_src_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_src_req <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        DMA_IDLE: begin
          if (start) begin
            r_base  <= src_base;
            r_count <= count;
            r_mask  <= block_mask;
            r_blk   <= lowest_onehot(block_mask);
            r_idx   <= '0;
            if (block_mask == 3'b000) begin
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= DMA_REQ;
            end
          end
        end
        DMA_REQ: begin
          if (vblank) begin
            r_src_req  <= 1'b1;
            r_src_addr <= r_base + w_offset;
            r_state    <= DMA_WAIT;
          end
        end
        // Completes even if vblank has dropped; the metadata port accepts writes at any time.
        DMA_WAIT: begin
          if (src_data_valid) begin
            r_hold  <= src_read_data;
            r_state <= DMA_WRITE;
          end
        end
        DMA_WRITE: begin
          if (w_dma_grant) r_state <= DMA_NEXT;
        end
        DMA_NEXT: begin
          if (w_last_idx) begin
            r_idx <= '0;
            if (w_next_blk == 3'b000) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= DMA_IDLE;
            end else begin
              r_blk   <= w_next_blk;
              r_state <= DMA_REQ;
            end
          end else begin
            r_idx   <= w_idx_inc[IDX_W-1:0];
            r_state <= DMA_REQ;
          end
        end
        default: r_state <= DMA_IDLE;
      endcase
    end
  end

  vdp_sprite_meta_write_mux u_mux (
    .clk         (clk),
    .reset       (reset),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_address),
    .i_cpu_dat   (cpu_write_data),
    .i_cpu_blk   (cpu_block_select),
    .i_dma_req   (w_dma_req),
    .i_dma_addr  (r_idx),
    .i_dma_dat   (r_hold),
    .i_dma_blk   (r_blk),
    .o_dma_grant (w_dma_grant),
    .o_meta_addr (meta_address),
    .o_meta_dat  (meta_write_data),
    .o_meta_blk  (meta_block_select),
    .o_meta_we   (meta_we)
  );

  assign src_read_address = r_src_addr;
  assign src_read_req     = r_src_req;
  assign busy             = r_busy;
  assign done             = r_done;

endmodule

// File: tb/tb_vdp_sprite_meta_dma.sv
// Directed bench for vdp_sprite_meta_dma with a variable-latency source memory and write monitor.
module tb_vdp_sprite_meta_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_base = '0;
  logic [7:0]  count = '0;
  logic [2:0]  block_mask = '0;
  logic        vblank = 1'b0;
  logic [7:0]  cpu_address = '0;
  logic [15:0] cpu_write_data = '0;
  logic [2:0]  cpu_block_select = '0;
  logic        cpu_we = 1'b0;
  logic [15:0] src_read_address;
  logic        src_read_req;
  logic [15:0] src_read_data = '0;
  logic        src_data_valid = 1'b0;
  logic [7:0]  meta_address;
  logic [15:0] meta_write_data;
  logic [2:0]  meta_block_select;
  logic        meta_we;
  logic        busy;
  logic        done;

  vdp_sprite_meta_dma #(.SRC_AW(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .src_base          (src_base),
    .count             (count),
    .block_mask        (block_mask),
    .vblank            (vblank),
    .cpu_address       (cpu_address),
    .cpu_write_data    (cpu_write_data),
    .cpu_block_select  (cpu_block_select),
    .cpu_we            (cpu_we),
    .src_read_address  (src_read_address),
    .src_read_req      (src_read_req),
    .src_read_data     (src_read_data),
    .src_data_valid    (src_data_valid),
    .meta_address      (meta_address),
    .meta_write_data   (meta_write_data),
    .meta_block_select (meta_block_select),
    .meta_we           (meta_we),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  blk;
    logic [7:0]  addr;
    logic [15:0] dat;
    int          cyc;
  } wr_t;

  wr_t         wr_q[$];
  logic [15:0] rd_q[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          lat = 2;
  int          mcnt = 0;
  logic [15:0] maddr = '0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [15:0] src_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Source memory: answers each request lat cycles after the request cycle.
  always @(negedge clk) begin
    src_data_valid <= (mcnt == 1);
    if (mcnt == 1) src_read_data <= src_word(maddr);
    if (src_read_req) begin
      maddr <= src_read_address;
      mcnt  <= lat;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end

  always @(negedge clk) begin
    if (meta_we) wr_q.push_back('{meta_block_select, meta_address, meta_write_data, cyc});
    if (src_read_req) rd_q.push_back(src_read_address);
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_dma(input logic [15:0] b, input logic [7:0] c, input logic [2:0] m);
    src_base = b; count = c; block_mask = m; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int n = 0; n < budget && done !== 1'b1; n++) tick(1);
    check(tag, done, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_req(input int budget, input string tag);
    for (int n = 0; n < budget && src_read_req !== 1'b1; n++) tick(1);
    check(tag, src_read_req, 1);
  endtask

  task automatic clear_logs();
    wr_q.delete();
    rd_q.delete();
  endtask

  initial begin
    int d0;
    int c0;

    // Reset state
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_meta_we", meta_we, 0);
    check("rst_req", src_read_req, 0);
    check("rst_src_addr", src_read_address, 0);
    check("rst_meta_addr", meta_address, 0);
    check("rst_meta_dat", meta_write_data, 0);
    check("rst_meta_blk", meta_block_select, 0);
    reset = 1'b0;
    tick(2);

    // Full three-block transfer, 256 entries each
    vblank = 1'b1; lat = 2; clear_logs(); d0 = done_cnt;
    start_dma(16'h1000, 8'd0, 3'b111);
    check("t1_busy", busy, 1);
    wait_done(12000, "t1_done");
    tick(3);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_done_low", done, 0);
    check("t1_nreads", rd_q.size(), 768);
    check("t1_nwrites", wr_q.size(), 768);
    for (int i = 0; i < 768 && i < rd_q.size(); i++)
      check("t1_rd_addr", rd_q[i], 32'h1000 + i);
    for (int i = 0; i < 768 && i < wr_q.size(); i++) begin
      check("t1_wr_blk", wr_q[i].blk, 32'(3'b001 << (i / 256)));
      check("t1_wr_idx", wr_q[i].addr, i % 256);
      check("t1_wr_dat", wr_q[i].dat, src_word(16'(16'h1000 + i)));
    end

    // g block only, base near the top of the address space
    lat = 1; clear_logs();
    start_dma(16'hFFFE, 8'd4, 3'b100);
    wait_done(200, "t2_done");
    tick(2);
    check("t2_nreads", rd_q.size(), 4);
    check("t2_nwrites", wr_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_q.size() && i < wr_q.size(); i++) begin
      check("t2_rd_addr", rd_q[i], 32'h01FE + i);
      check("t2_wr_blk", wr_q[i].blk, 3'b100);
      check("t2_wr_idx", wr_q[i].addr, i);
      check("t2_wr_dat", wr_q[i].dat, src_word(16'(16'h01FE + i)));
    end

    // CPU writes hold off the DMA write for 5 cycles
    lat = 3; clear_logs();
    start_dma(16'h2000, 8'd1, 3'b001);
    for (int n = 0; n < 50 && src_data_valid !== 1'b1; n++) tick(1);
    check("t3_valid_seen", src_data_valid, 1);
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      cpu_address = 8'(10 + k); cpu_write_data = 16'(16'hC000 + k);
      cpu_block_select = 3'b010; cpu_we = 1'b1;
      tick(1);
    end
    cpu_we = 1'b0;
    wait_done(50, "t3_done");
    tick(2);
    check("t3_nwrites", wr_q.size(), 6);
    for (int k = 0; k < 5 && k < wr_q.size(); k++) begin
      check("t3_cpu_cyc", wr_q[k].cyc, c0 + 1 + k);
      check("t3_cpu_blk", wr_q[k].blk, 3'b010);
      check("t3_cpu_addr", wr_q[k].addr, 10 + k);
      check("t3_cpu_dat", wr_q[k].dat, 32'hC000 + k);
    end
    if (wr_q.size() == 6) begin
      check("t3_dma_cyc", wr_q[5].cyc, c0 + 6);
      check("t3_dma_blk", wr_q[5].blk, 3'b001);
      check("t3_dma_addr", wr_q[5].addr, 0);
      check("t3_dma_dat", wr_q[5].dat, src_word(16'h2000));
    end

    // vblank drops while a read is in flight
    lat = 4; clear_logs();
    start_dma(16'h3000, 8'd3, 3'b010);
    wait_req(20, "t4_req");
    vblank = 1'b0;
    tick(15);
    check("t4_stall_busy", busy, 1);
    check("t4_stall_nreads", rd_q.size(), 1);
    check("t4_stall_nwrites", wr_q.size(), 1);
    if (wr_q.size() >= 1) begin
      check("t4_pend_idx", wr_q[0].addr, 0);
      check("t4_pend_dat", wr_q[0].dat, src_word(16'h3100));
    end
    vblank = 1'b1;
    wait_done(100, "t4_done");
    tick(2);
    check("t4_nreads", rd_q.size(), 3);
    check("t4_nwrites", wr_q.size(), 3);
    for (int i = 1; i < 3 && i < rd_q.size() && i < wr_q.size(); i++) begin
      check("t4_rd_addr", rd_q[i], 32'h3100 + i);
      check("t4_wr_idx", wr_q[i].addr, i);
      check("t4_wr_dat", wr_q[i].dat, src_word(16'(16'h3100 + i)));
    end

    // Empty mask completes immediately
    clear_logs(); d0 = done_cnt;
    start_dma(16'h4000, 8'd5, 3'b000);
    check("t5_done_pulse", done, 1);
    check("t5_busy", busy, 0);
    tick(1);
    check("t5_done_low", done, 0);
    tick(4);
    check("t5_nreads", rd_q.size(), 0);
    check("t5_nwrites", wr_q.size(), 0);
    check("t5_done_once", done_cnt - d0, 1);

    // start while busy is ignored
    lat = 2; clear_logs();
    start_dma(16'h5000, 8'd2, 3'b001);
    tick(3);
    start_dma(16'h6000, 8'd8, 3'b111);
    wait_done(100, "t5b_done");
    tick(10);
    check("t5b_nreads", rd_q.size(), 2);
    check("t5b_nwrites", wr_q.size(), 2);
    for (int i = 0; i < 2 && i < rd_q.size(); i++)
      check("t5b_rd_addr", rd_q[i], 32'h5000 + i);
    check("t5b_idle_busy", busy, 0);

    // Reset during WAIT, late data must be dropped
    lat = 5; clear_logs(); d0 = done_cnt;
    start_dma(16'h7000, 8'd1, 3'b001);
    wait_req(20, "t6_req");
    tick(1);
    reset = 1'b1; start = 1'b1; block_mask = 3'b001;
    tick(1);
    start = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(10);
    check("t6_nwrites", wr_q.size(), 0);
    check("t6_busy", busy, 0);
    check("t6_done_cnt", done_cnt - d0, 0);
    check("t6_meta_we", meta_we, 0);
    check("t6_req", src_read_req, 0);
    check("t6_src_addr", src_read_address, 0);
    check("t6_meta_addr", meta_address, 0);
    check("t6_meta_dat", meta_write_data, 0);
    check("t6_meta_blk", meta_block_select, 0);

    lat = 1; clear_logs();
    start_dma(16'h7100, 8'd1, 3'b001);
    check("t6_restart_busy", busy, 1);
    wait_done(50, "t6_restart_done");
    tick(2);
    check("t6_restart_nreads", rd_q.size(), 1);
    check("t6_restart_nwrites", wr_q.size(), 1);
    if (rd_q.size() == 1 && wr_q.size() == 1) begin
      check("t6_restart_rd", rd_q[0], 32'h7100);
      check("t6_restart_dat", wr_q[0].dat, src_word(16'h7100));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
